// File: rtl/hazard_control_unit.sv
// Hazard controller: load-use stalls, branch flushes, dmem freeze with timeout.
// Optional HAZARD_PERF_CNT_EN adds stall_cycles / flush_count counters.
module hazard_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] idata_ID,
  input  logic [31:0] idata_EX,
  input  logic        memread_EX,
  input  logic        branch_taken_EX,
  input  logic        dmem_req_MEM,
  input  logic        dmem_ack,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_write,
  output logic        idex_flush,
  output logic        exmem_write,
  output logic        memwb_write,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
`endif
  output logic        mem_err
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  localparam logic [CNT_W-1:0] TO   = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;

  logic [0:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic [6:0] opcode;
  logic       uses_rs2;
  logic       load_use;
  logic       freeze;
  logic       sel_rst;
  logic       sel_frz;
  logic       sel_br;
  logic       sel_lu;
  logic       unused_bits;

  assign rs1    = idata_ID[19:15];
  assign rs2    = idata_ID[24:20];
  assign opcode = idata_ID[6:0];
  assign rd     = idata_EX[11:7];

  assign unused_bits = ^{idata_ID[31:25], idata_ID[14:7],
                         idata_EX[31:12], idata_EX[6:0]};

  assign uses_rs2 = (opcode == OP_R) ||
                    (opcode == OP_S) ||
                    (opcode == OP_B);

  assign load_use = memread_EX && (rd != 5'd0) &&
                    ((rd == rs1) || (uses_rs2 && (rd == rs2)));

  assign freeze =
    ((state == RUN) && dmem_req_MEM && !dmem_ack) ||
    ((state == MEM_WAIT) && !dmem_ack && (wait_cnt < TO));

  // Mutually exclusive selects encode the priority
  assign sel_rst = rst;
  assign sel_frz = !rst && freeze;
  assign sel_br  = !rst && !freeze && branch_taken_EX;
  assign sel_lu  = !rst && !freeze && !branch_taken_EX && load_use;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    memwb_write = 1'b1;
    unique case (1'b1)
      sel_rst, sel_frz: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
        memwb_write = 1'b0;
      end
      sel_br: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      sel_lu: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (dmem_req_MEM && !dmem_ack) begin
            state    <= MEM_WAIT;
            wait_cnt <= CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (dmem_ack) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt >= TO) begin
            // Abandon the hung access and release the pipe
            state    <= RUN;
            wait_cnt <= '0;
            err_q    <= 1'b1;
          end else if (wait_cnt != CMAX) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  assign mem_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (sel_frz || sel_lu)
        stall_cycles <= stall_cycles + 32'd1;
      if (sel_br)
        flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule
